// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: parallel-in, serial-out stimulus transmitter.
// Takes a word over a valid/ready handshake and shifts it out MSB-first on
// `out`. Each bit is held for HOLD clocks. The block also keeps a saturating
// count of every 1->0 transition it puts on `out`.
//
// Handshake: a word transfers on the rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. in_data/in_len are sampled only on that edge.
// In other states in_valid is ignored, and nothing is queued.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2,
  parameter int CNTW  = 8,
  parameter int LENW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LENW-1:0]  in_len,
  input  logic             clr_cnt,
  output logic             out,
  output logic [1:0]       state,
  output logic             done,
  output logic [CNTW-1:0]  fall_cnt
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_SEND = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam int              HW      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_M1 = HW'(HOLD - 1);
  localparam logic [LENW-1:0] WIDTH_L = LENW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LENW-1:0]  bits_q,  bits_d;   // bits still to send after the current one
  logic [HW-1:0]    hold_q,  hold_d;   // remaining extra cycles for the current bit
  logic             out_q,   out_d;
  logic [CNTW-1:0]  fall_q,  fall_d;

  logic [LENW-1:0]  len_eff;
  logic [WIDTH-1:0] aligned;

  // Effective length: 0 or an oversize length means a full-width word.
  // The word is left-aligned, so its first bit always sits in the MSB of the shifter.
  always_comb begin
    len_eff = ((in_len == '0) || (in_len > WIDTH_L)) ? WIDTH_L : in_len;
    aligned = in_data << (WIDTH_L - len_eff);
  end

  // Next-state logic for the FSM, the shifter, the bit and hold counters, and the serial bit
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    hold_d  = hold_q;
    out_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SEND;
          shift_d = aligned;
          bits_d  = len_eff - LENW'(1);
          hold_d  = HOLD_M1;
          out_d   = aligned[WIDTH-1];
        end
      end
      S_SEND: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
          out_d  = out_q;
        end else if (bits_q == '0) begin
          state_d = S_DONE;
          out_d   = 1'b0;
        end else begin
          shift_d = shift_q << 1;
          bits_d  = bits_q - LENW'(1);
          hold_d  = HOLD_M1;
          out_d   = shift_q[WIDTH-2];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        // Encoding 11 is unreachable. Recover to a clean IDLE.
        state_d = S_IDLE;
        shift_d = '0;
        bits_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Falling-edge counter: a clear wins over an increment, and the count saturates at all-ones
  always_comb begin
    fall_d = fall_q;
    if (clr_cnt) begin
      fall_d = '0;
    end else if (out_q && !out_d && (fall_q != {CNTW{1'b1}})) begin
      fall_d = fall_q + CNTW'(1);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bits_q  <= '0;
      hold_q  <= '0;
      out_q   <= 1'b0;
      fall_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      fall_q  <= fall_d;
    end
  end

  assign out      = out_q;
  assign state    = state_q;
  assign in_ready = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign fall_cnt = fall_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen. Instance a uses the default parameters.
// Instance b uses CNTW=2 to reach counter saturation. Inputs change on the
// falling edge and outputs are sampled there. Cycle i means the i-th cycle
// after the accept cycle (cycle 0).
module tb_serial_pattern_gen;
  localparam int WIDTH = 8;
  localparam int LENW  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [LENW-1:0]  in_len = '0;

  logic       in_ready_a, out_a, done_a;
  logic [1:0] state_a;
  logic [7:0] fall_a;
  logic       in_ready_b, out_b, done_b;
  logic [1:0] state_b;
  logic [1:0] fall_b;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0]  pat6;
  logic [18:0] stream;
  logic [7:0]  aa;

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(8), .HOLD(2), .CNTW(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_len(in_len), .clr_cnt(clr_cnt), .out(out_a),
    .state(state_a), .done(done_a), .fall_cnt(fall_a)
  );

  serial_pattern_gen #(.WIDTH(8), .HOLD(2), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_len(in_len), .clr_cnt(clr_cnt), .out(out_b),
    .state(state_b), .done(done_b), .fall_cnt(fall_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted mid-clock, with no edge yet
    #2 rst = 1'b1;
    #1;
    chk("rst_out", out_a, 1'b0);
    chk("rst_state", state_a, 2'b00);
    chk("rst_ready", in_ready_a, 1'b1);
    chk("rst_done", done_a, 1'b0);
    chk("rst_fall_a", fall_a, 8'd0);
    chk("rst_fall_b", fall_b, 2'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Single word 3'b010 at length 3. Inputs change after accept and must have no effect.
    in_valid = 1'b1; in_data = 8'b0000_0010; in_len = 4'd3;
    chk("sw_ready_acc", in_ready_a, 1'b1);
    pat6 = 6'b001100;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) begin
        in_valid = 1'b0; in_data = 8'hFF; in_len = 4'd0;
        chk("sw_state_send", state_a, 2'b01);
      end
      chk("sw_out", out_a, pat6[5-i]);
      chk("sw_ready_lo", in_ready_a, 1'b0);
    end
    cyc();
    chk("sw_done", done_a, 1'b1);
    chk("sw_done_out", out_a, 1'b0);
    chk("sw_done_state", state_a, 2'b10);
    cyc();
    chk("sw_ready_back", in_ready_a, 1'b1);
    chk("sw_done_lo", done_a, 1'b0);
    chk("sw_fall", fall_a, 8'd1);

    // Clear pulse in IDLE
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr_idle", fall_a, 8'd0);

    // Back-to-back: "110" then "11110", with in_valid held high
    in_valid = 1'b1; in_data = 8'b0000_0110; in_len = 4'd3;
    stream = 19'b1111_0000_1111_1111_000;
    for (int i = 1; i <= 19; i++) begin
      cyc();
      if (i == 1) begin in_data = 8'b0001_1110; in_len = 4'd5; end
      if (i == 9) in_valid = 1'b0;
      chk("b2b_out", out_a, stream[19-i]);
      if (i == 5) chk("b2b_ready_lo", in_ready_a, 1'b0);
      if (i == 7 || i == 19) chk("b2b_done", done_a, 1'b1);
      if (i == 8) chk("b2b_ready_acc", in_ready_a, 1'b1);
    end
    cyc();
    chk("b2b_ready_end", in_ready_a, 1'b1);
    chk("b2b_fall", fall_a, 8'd2);

    // Full width: len 0 with 8'hFF
    in_valid = 1'b1; in_data = 8'hFF; in_len = 4'd0;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (i == 1) in_valid = 1'b0;
      if (i <= 16) chk("fw_out", out_a, 1'b1);
      if (i == 16) chk("fw_fall_pre", fall_a, 8'd2);
      if (i == 17) begin
        chk("fw_done", done_a, 1'b1);
        chk("fw_done_out", out_a, 1'b0);
        chk("fw_fall_post", fall_a, 8'd3);
      end
    end
    cyc();
    chk("fw_ready", in_ready_a, 1'b1);

    // Reset in the middle of bit 2 of 8'hAA
    in_valid = 1'b1; in_data = 8'hAA; in_len = 4'd8;
    cyc();
    in_valid = 1'b0;
    chk("rm_bit0", out_a, 1'b1);
    cyc(); cyc(); cyc(); cyc();
    chk("rm_bit2", out_a, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rm_out", out_a, 1'b0);
    chk("rm_state", state_a, 2'b00);
    chk("rm_ready", in_ready_a, 1'b1);
    chk("rm_fall", fall_a, 8'd0);
    cyc();
    rst = 1'b0;
    // Oversize length 12 acts as a full-width word
    in_valid = 1'b1; in_data = 8'h01; in_len = 4'd12;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (i == 1) in_valid = 1'b0;
      if (i <= 16) chk("rm_new_out", out_a, (i >= 15) ? 1'b1 : 1'b0);
      if (i == 17) begin
        chk("rm_new_done", done_a, 1'b1);
        chk("rm_new_fall", fall_a, 8'd1);
      end
    end
    cyc();

    // Saturation on the 2-bit counter, then a clear
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("sat_clr0", fall_b, 2'd0);
    aa = 8'hAA;
    in_valid = 1'b1; in_data = 8'hAA; in_len = 4'd8;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      if (i == 1) in_valid = 1'b0;
      if (i <= 16) chk("sat_out", out_b, aa[7 - (i - 1) / 2]);
      if (i == 3)  chk("sat_fall1", fall_b, 2'd1);
      if (i == 7)  chk("sat_fall2", fall_b, 2'd2);
      if (i == 11) chk("sat_fall3", fall_b, 2'd3);
      if (i == 15) begin
        chk("sat_hold", fall_b, 2'd3);
        chk("sat_full_cnt", fall_a, 8'd4);
      end
      if (i == 16) clr_cnt = 1'b1;
      if (i == 17) begin
        clr_cnt = 1'b0;
        chk("sat_clr_b", fall_b, 2'd0);
        chk("sat_clr_a", fall_a, 8'd0);
        chk("sat_done_b", done_b, 1'b1);
      end
    end
    cyc();

    // Clear on the same edge as a fall: the clear wins
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 1) in_valid = 1'b0;
      if (i == 2) clr_cnt = 1'b1;
      if (i == 3) begin
        clr_cnt = 1'b0;
        chk("clr_fall_out", out_a, 1'b0);
        chk("clr_fall_a", fall_a, 8'd0);
        chk("clr_fall_b", fall_b, 2'd0);
      end
      if (i == 7) begin
        chk("after_clr_a", fall_a, 8'd1);
        chk("after_clr_b", fall_b, 2'd1);
      end
    end
    repeat (10) cyc();
    chk("end_ready", in_ready_a, 1'b1);
    chk("end_state", state_b, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
